// File: rtl/axi_sram_if.sv
// AXI3 read/write channel bundle between a burst master and axi_sram_slave.
interface axi_sram_if #(
  parameter int ID_W = 4
) ();
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 burst slave over a word-addressed RAM with independent read and write FSMs.
// Define AXI_SLV_RAND_STALL_EN to add LFSR-driven pseudo-random ready/valid stalls.
module axi_sram_slave #(
  parameter int MEM_AW = 12,
  parameter int ID_W   = 4
) (
  input logic       clk,
  input logic       resetn,
  axi_sram_if.slave bus
);
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;
  localparam logic [1:0] W_IDLE  = 2'b00;
  localparam logic [1:0] W_DATA  = 2'b01;
  localparam logic [1:0] W_RESP  = 2'b10;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    return (size != 3'b010) || (burst == 2'b11) || bad_wrap;
  endfunction

  // WRAP keeps the upper index bits and lets the low len-sized field roll over.
  function automatic logic [MEM_AW-1:0] next_idx(input logic [MEM_AW-1:0] idx,
                                                 input logic [1:0] burst,
                                                 input logic [3:0] wrap_len);
    logic [MEM_AW-1:0] mask;
    logic [MEM_AW-1:0] inc;
    logic [MEM_AW-1:0] res;
    mask      = '0;
    mask[3:0] = wrap_len;
    inc       = idx + {{(MEM_AW-1){1'b0}}, 1'b1};
    case (burst)
      2'b01:   res = inc;
      2'b10:   res = (idx & ~mask) | (inc & mask);
      default: res = idx;
    endcase
    return res;
  endfunction

  logic stall_r_s;
  logic stall_w_s;

`ifdef AXI_SLV_RAND_STALL_EN
  logic [15:0] lfsr_r;

  // Free-running x^16+x^14+x^13+x^11+1 LFSR; two bit pairs give ~25% stall per channel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  assign stall_r_s = (lfsr_r[1:0] == 2'b00);
  assign stall_w_s = (lfsr_r[5:4] == 2'b00);
`else
  assign stall_r_s = 1'b0;
  assign stall_w_s = 1'b0;
`endif

  logic [0:0]        r_state_r;
  logic              arready_r, rvalid_r, rlast_r, r_err_r;
  logic [31:0]       rdata_r;
  logic [1:0]        rresp_r, r_burst_r;
  logic [ID_W-1:0]   rid_r;
  logic [MEM_AW-1:0] r_idx_r;
  logic [7:0]        r_rem_r;
  logic [3:0]        r_wrap_r;

  logic              ar_hs_s, r_hs_s, ar_err_s;
  logic [MEM_AW-1:0] ar_idx_s, r_next_s;

  assign ar_hs_s  = bus.arvalid & arready_r;
  assign r_hs_s   = rvalid_r & bus.rready;
  assign ar_err_s = burst_err(bus.arsize, bus.arburst, bus.arlen);
  assign ar_idx_s = bus.araddr[MEM_AW+1:2];
  assign r_next_s = next_idx(r_idx_r, r_burst_r, r_wrap_r);

  // Read FSM: accept AR, then stream beats with the next word prefetched on each handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rdata_r   <= 32'h0;
      rresp_r   <= 2'b00;
      rid_r     <= '0;
      r_idx_r   <= '0;
      r_rem_r   <= 8'd0;
      r_wrap_r  <= 4'd0;
      r_burst_r <= 2'b00;
      r_err_r   <= 1'b0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            arready_r <= 1'b0;
            rid_r     <= bus.arid;
            r_idx_r   <= ar_idx_s;
            r_rem_r   <= bus.arlen;
            r_wrap_r  <= bus.arlen[3:0];
            r_burst_r <= bus.arburst;
            r_err_r   <= ar_err_s;
            rdata_r   <= ar_err_s ? 32'h0 : mem[ar_idx_s];
            rresp_r   <= ar_err_s ? 2'b10 : 2'b00;
            rlast_r   <= (bus.arlen == 8'd0);
            rvalid_r  <= ~stall_r_s;
            r_state_r <= R_BURST;
          end else begin
            arready_r <= ~stall_r_s;
          end
        end
        R_BURST: begin
          if (r_hs_s) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= ~stall_r_s;
              r_state_r <= R_IDLE;
            end else begin
              r_idx_r  <= r_next_s;
              rdata_r  <= r_err_r ? 32'h0 : mem[r_next_s];
              r_rem_r  <= r_rem_r - 8'd1;
              rlast_r  <= (r_rem_r == 8'd1);
              rvalid_r <= ~stall_r_s;
            end
          end else if (!rvalid_r) begin
            rvalid_r <= ~stall_r_s;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  logic [1:0]        w_state_r;
  logic              awready_r, wready_r, bvalid_r, w_err_r;
  logic [1:0]        bresp_r, w_burst_r;
  logic [ID_W-1:0]   bid_r;
  logic [MEM_AW-1:0] w_idx_r;
  logic [7:0]        w_rem_r;
  logic [3:0]        w_wrap_r;

  logic              aw_hs_s, w_hs_s, b_hs_s, w_beat_err_s;
  logic [MEM_AW-1:0] w_next_s;

  assign aw_hs_s      = bus.awvalid & awready_r;
  assign w_hs_s       = bus.wvalid & wready_r;
  assign b_hs_s       = bvalid_r & bus.bready;
  assign w_next_s     = next_idx(w_idx_r, w_burst_r, w_wrap_r);
  assign w_beat_err_s = w_err_r | (bus.wid != bid_r) | (bus.wlast != (w_rem_r == 8'd0));

  // Write FSM: accept AW, absorb beats until wlast or the count runs out, then respond.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      bid_r     <= '0;
      w_idx_r   <= '0;
      w_rem_r   <= 8'd0;
      w_wrap_r  <= 4'd0;
      w_burst_r <= 2'b00;
      w_err_r   <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            awready_r <= 1'b0;
            bid_r     <= bus.awid;
            w_idx_r   <= bus.awaddr[MEM_AW+1:2];
            w_rem_r   <= bus.awlen;
            w_wrap_r  <= bus.awlen[3:0];
            w_burst_r <= bus.awburst;
            w_err_r   <= burst_err(bus.awsize, bus.awburst, bus.awlen);
            wready_r  <= ~stall_w_s;
            w_state_r <= W_DATA;
          end else begin
            awready_r <= ~stall_w_s;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            w_err_r <= w_beat_err_s;
            if (bus.wlast || (w_rem_r == 8'd0)) begin
              wready_r  <= 1'b0;
              bvalid_r  <= ~stall_w_s;
              bresp_r   <= w_beat_err_s ? 2'b10 : 2'b00;
              w_state_r <= W_RESP;
            end else begin
              w_idx_r  <= w_next_s;
              w_rem_r  <= w_rem_r - 8'd1;
              wready_r <= ~stall_w_s;
            end
          end else begin
            wready_r <= ~stall_w_s;
          end
        end
        W_RESP: begin
          if (b_hs_s) begin
            bvalid_r  <= 1'b0;
            awready_r <= ~stall_w_s;
            w_state_r <= W_IDLE;
          end else if (!bvalid_r) begin
            bvalid_r <= ~stall_w_s;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // RAM byte-lane write; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_hs_s && !w_beat_err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[w_idx_r][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.arready = arready_r;
  assign bus.rid     = rid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign bus.rlast   = rlast_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.awready = awready_r;
  assign bus.wready  = wready_r;
  assign bus.bid     = bid_r;
  assign bus.bresp   = bresp_r;
  assign bus.bvalid  = bvalid_r;
endmodule
